// File: rtl/rr_share_arbiter_pkg.sv
// Shared types and helpers for the round-robin share arbiter.
// Used by rr_share_arbiter and rr_pick.
package share_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } share_arb_state_t;

    localparam int MAX_REQ = 32;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_share_arbiter_rr_pick.sv
// Rotate-priority encoder: first requester found scanning ptr, ptr+1, ...
// wrapping from N-1 back to 0. Purely combinational.
module rr_pick
    import share_arb_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] w_pos;

    // Scan downward so the position closest to ptr is the last to write gnt_idx.
    always_comb begin
        gnt_vld = |req;
        gnt_idx = '0;
        w_pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = IDX_W'((int'(ptr) + k) % N);
            if (req[w_pos]) begin
                gnt_idx = w_pos;
            end
        end
    end

endmodule

// File: rtl/rr_share_arbiter.sv
// Round-robin arbiter sharing one valid/ready consumer between N producers,
// with a one-entry registered output stage.
// Optional feature macro: SHARE_ARB_LOCK_EN (adds in_lock and grant locking).
//
// state | meaning
// EMPTY | output register free, out_valid=0
// FULL  | output register holds a payload, out_valid=1
module rr_share_arbiter
    import share_arb_pkg::*;
#(
    parameter  type T     = bit,
    parameter  int  N     = 4,
    localparam int  IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  T                 in_data [N],
    output logic             out_valid,
    input  logic             out_ready,
    output T                 out_data,
    output logic [IDX_W-1:0] out_idx
`ifdef SHARE_ARB_LOCK_EN
    ,
    input  logic [N-1:0]     in_lock
`endif
);

    share_arb_state_t r_state;
    share_arb_state_t w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    T                 r_data;
    logic [IDX_W-1:0] r_idx;

    logic [N-1:0]     w_req;
    logic [N-1:0]     w_sel;
    logic             w_gnt_vld;
    logic [IDX_W-1:0] w_gnt_idx;
    T                 w_gnt_data;
    logic             w_slot_free;
    logic             w_accept;
    logic             w_advance;

`ifdef SHARE_ARB_LOCK_EN
    logic             r_lock_act;
    logic [IDX_W-1:0] r_lock_idx;
    logic             w_gnt_lock;

    // While locked, only the lock holder is visible to the picker.
    always_comb begin
        w_req = in_valid;
        if (r_lock_act) begin
            for (int i = 0; i < N; i++) begin
                w_req[i] = in_valid[i] & (r_lock_idx == IDX_W'(i));
            end
        end
    end

    assign w_gnt_lock = |(in_lock & w_sel);
    // A locked accept keeps ptr frozen; rotation resumes from the unlocking accept.
    assign w_advance  = w_accept & ~w_gnt_lock;

    // Lock holder is captured on every accept; the lock bit follows in_lock of that accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_act <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_accept) begin
            r_lock_act <= w_gnt_lock;
            r_lock_idx <= w_gnt_idx;
        end
    end
`else
    assign w_req     = in_valid;
    assign w_advance = w_accept;
`endif

    rr_pick #(
        .N (N)
    ) u_pick (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt_vld (w_gnt_vld),
        .gnt_idx (w_gnt_idx)
    );

    // One-hot of the picked index plus the matching payload.
    always_comb begin
        w_sel      = '0;
        w_gnt_data = in_data[0];
        for (int i = 0; i < N; i++) begin
            w_sel[i] = (w_gnt_idx == IDX_W'(i));
            if (w_gnt_idx == IDX_W'(i)) begin
                w_gnt_data = in_data[i];
            end
        end
    end

    assign w_slot_free = (r_state == EMPTY) | out_ready;
    assign w_accept    = ~rst & w_slot_free & w_gnt_vld;
    assign in_ready    = w_accept ? w_sel : '0;
    assign out_valid   = (r_state == FULL);
    assign out_data    = r_data;
    assign out_idx     = r_idx;

    // Next-state: fill on accept, drain only when the consumer takes it and nothing refills.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_state_nxt = FULL;
            FULL:    if (out_ready && !w_accept) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Rotation pointer moves just past the requester that was served.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_advance) begin
            w_ptr_nxt = (w_gnt_idx == IDX_W'(N - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Output stage loads on accept and otherwise holds, which keeps data stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_data <= w_gnt_data;
            r_idx  <= w_gnt_idx;
        end
    end

endmodule

// File: tb/tb_rr_share_arbiter.sv
// Self-checking bench for rr_share_arbiter (N=4, 32-bit payload).
// Builds with or without SHARE_ARB_LOCK_EN.
module tb_rr_share_arbiter;

    localparam int N = 4;
    typedef logic [31:0] word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    word_t       in_data [N];
    logic        out_valid;
    logic        out_ready;
    word_t       out_data;
    logic [1:0]  out_idx;
    logic [3:0]  lk;
`ifdef SHARE_ARB_LOCK_EN
    logic [3:0]  in_lock;
    assign in_lock = lk;
`endif

    rr_share_arbiter #(
        .T (word_t),
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx)
`ifdef SHARE_ARB_LOCK_EN
        ,
        .in_lock   (in_lock)
`endif
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_fail = 0;

    // reference model state
    bit    m_valid;
    word_t m_data;
    int    m_idx;
    int    m_ptr;
    bit    m_lock;
    int    m_lock_idx;
    logic [3:0] last_rdy;
    word_t held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One cycle: drive at negedge, compare against the model, advance the model at posedge.
    task automatic step(input logic [3:0] v, input logic ro, input logic r);
        int         pk;
        logic [3:0] v_eff;
        logic [3:0] exp_rdy;
        bit         slot;
        in_valid  = v;
        out_ready = ro;
        rst       = r;
        #1;
        v_eff = v;
        if (m_lock) v_eff = v & (4'b0001 << m_lock_idx);
        slot    = !m_valid || ro;
        pk      = model_pick(v_eff, m_ptr);
        exp_rdy = '0;
        if (!r && slot && pk >= 0) exp_rdy[pk] = 1'b1;
        last_rdy = in_ready;
        chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_data", out_data, m_data);
        chk("out_idx", {30'd0, out_idx}, m_idx);
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_data = '0; m_idx = 0; m_ptr = 0; m_lock = 0; m_lock_idx = 0;
        end else if (exp_rdy != 4'b0000) begin
            m_valid = 1;
            m_data  = in_data[pk];
            m_idx   = pk;
`ifdef SHARE_ARB_LOCK_EN
            if (lk[pk]) begin
                m_lock     = 1;
                m_lock_idx = pk;
            end else begin
                m_lock = 0;
                m_ptr  = (pk + 1) % N;
            end
`else
            m_ptr = (pk + 1) % N;
`endif
        end else if (ro) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    logic [3:0] pend;
    logic [3:0] grants [5];

    initial begin
        rst = 1'b1; in_valid = '0; out_ready = 1'b0; lk = '0;
        for (int i = 0; i < N; i++) in_data[i] = 32'h1000_0000 + i;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_valid = 0; m_data = '0; m_idx = 0; m_ptr = 0; m_lock = 0; m_lock_idx = 0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_idx", {30'd0, out_idx}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_in_ready", {28'd0, in_ready}, 32'd0);

        // all requesting, consumer always ready: strict rotation
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, 1'b1, 1'b0);
            grants[c] = last_rdy;
        end
        chk("rot0", {28'd0, grants[0]}, 32'b0001);
        chk("rot1", {28'd0, grants[1]}, 32'b0010);
        chk("rot2", {28'd0, grants[2]}, 32'b0100);
        chk("rot3", {28'd0, grants[3]}, 32'b1000);
        chk("rot4", {28'd0, grants[4]}, 32'b0001);
        #1;
        chk("rot_idx_follow", {30'd0, out_idx}, 32'd0);

        // serve req 1 so ptr lands on 2, then only 0 and 1 request
        in_data[1] = 32'hDEAD_BEEF;
        step(4'b0010, 1'b1, 1'b0);
        chk("beef_data", out_data, 32'hDEAD_BEEF);
        chk("beef_idx", {30'd0, out_idx}, 32'd1);
        step(4'b0011, 1'b1, 1'b0);
        chk("ptr2_pick", {28'd0, last_rdy}, 32'b0001);
        chk("ptr2_idx", {30'd0, out_idx}, 32'd0);
        step(4'b0011, 1'b1, 1'b0);
        chk("ptr1_pick", {28'd0, last_rdy}, 32'b0010);

        // backpressure: single requester, consumer stalls 3 cycles
        in_data[2] = 32'h0000_00A2;
        step(4'b0100, 1'b1, 1'b0);
        held = 32'h0000_00A2;
        in_data[2] = 32'h0000_00B2;
        for (int c = 0; c < 3; c++) begin
            step(4'b0100, 1'b0, 1'b0);
            chk("stall_rdy", {28'd0, last_rdy}, 32'd0);
        end
        chk("stall_data", out_data, held);
        step(4'b0100, 1'b1, 1'b0);
        chk("release_accept", {28'd0, last_rdy}, 32'b0100);

        // reset while FULL
        step(4'b1111, 1'b0, 1'b1);
        chk("rst_full_rdy", {28'd0, last_rdy}, 32'd0);
        #1;
        chk("rst_full_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_full_idx", {30'd0, out_idx}, 32'd0);
        step(4'b1111, 1'b1, 1'b0);
        chk("rst_full_ptr0", {28'd0, last_rdy}, 32'b0001);

        // no requests: nothing accepted, output drains
        step(4'b0000, 1'b1, 1'b0);
        chk("idle_rdy", {28'd0, last_rdy}, 32'd0);

`ifdef SHARE_ARB_LOCK_EN
        step(4'b0000, 1'b1, 1'b1);
        lk = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            step(4'b0110, 1'b1, 1'b0);
            chk("lock_hold", {28'd0, last_rdy}, 32'b0010);
        end
        lk = 4'b0000;
        step(4'b0110, 1'b1, 1'b0);
        chk("lock_release", {28'd0, last_rdy}, 32'b0010);
        step(4'b0110, 1'b1, 1'b0);
        chk("lock_next", {28'd0, last_rdy}, 32'b0100);
`endif

        // randomized producers honouring valid/data stability
        pend = '0;
        lk   = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i]    = 1'b1;
                    in_data[i] = $urandom;
`ifdef SHARE_ARB_LOCK_EN
                    lk[i]      = ($urandom_range(3, 0) == 0);
`endif
                end
            end
            step(pend, ($urandom_range(3, 0) != 0), ($urandom_range(49, 0) == 0));
            for (int i = 0; i < N; i++) begin
                if (last_rdy[i]) pend[i] = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
